// File: rtl/kyber_arith_pkg.sv
// Shared arithmetic defaults, Barrett constant helper and butterfly mode encodings.
package kyber_arith_pkg;

  localparam int KYBER_W = 12;
  localparam int KYBER_Q = 3329;

  typedef enum logic [1:0] {
    MODE_CT     = 2'b00,
    MODE_GS     = 2'b01,
    MODE_ADDSUB = 2'b10,
    MODE_MUL    = 2'b11
  } mode_e;

  // floor(2^(2w) / q), the Barrett multiplier for products below q^2
  function automatic longint unsigned barrett_m(input int w, input int q);
    return (64'd1 << (2 * w)) / 64'(q);
  endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// Modular multiplier: registered W x W product, then registered Barrett reduction.
// Two cycles of latency; both registers advance only while en is high.
module mod_mul_barrett
  import kyber_arith_pkg::*;
#(
  parameter int W = KYBER_W,
  parameter int Q = KYBER_Q
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] r
);

  localparam longint unsigned M  = barrett_m(W, Q);
  localparam int              MW = $clog2(M + 1);
  localparam logic [MW-1:0]   M_V = MW'(M);
  localparam logic [W+1:0]    Q_X = (W + 2)'(Q);

  logic [2*W-1:0] prod_q;
  logic [MW-1:0]  qhat;
  logic [2*W-1:0] qq;
  logic [W+1:0]   rem;
  logic [W+1:0]   red;
  logic [W-1:0]   r_q;

  // product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else if (en) prod_q <= (2 * W)'(x) * (2 * W)'(y);
  end

  // Barrett estimate; the quotient estimate is at most one short, so one
  // conditional subtract finishes the reduction
  always_comb begin
    qhat = MW'(((2 * W + MW)'(prod_q) * (2 * W + MW)'(M_V)) >> (2 * W));
    qq   = (2 * W)'(qhat) * (2 * W)'(Q_X);
    rem  = (W + 2)'(prod_q - qq);
    red  = (rem >= Q_X) ? rem - Q_X : rem;
  end

  // reduced result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else if (en) r_q <= W'(red);
  end

  assign r = r_q;

endmodule

// File: rtl/butterfly_array.sv
// LANES independent modular butterflies (CT / GS / add-sub / multiply) in a
// 4-stage pipeline with valid/ready flow control and a returned tag.
// A beat enters S0 on its accepting edge and appears at the outputs after the
// fourth register edge (S0, S1, S2, S3) when nothing stalls.
module butterfly_array
  import kyber_arith_pkg::*;
#(
  parameter int W     = KYBER_W,
  parameter int Q     = KYBER_Q,
  parameter int LANES = 2,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic                 in_half,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES*W-1:0]   in_tw,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_0,
  output logic [LANES*W-1:0]   out_1,
  output logic [TAG_W-1:0]     out_tag
);

  localparam logic [W:0] Q_E = (W + 1)'(Q);

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_E) s = s - Q_E;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = d + Q_E;
    return d[W-1:0];
  endfunction

  // x/2 mod Q: odd values borrow Q first so the shift is exact
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] h;
    h = x[0] ? (({1'b0, x} + Q_E) >> 1) : ({1'b0, x} >> 1);
    return h[W-1:0];
  endfunction

  logic              adv;
  mode_e             in_mode_e;
  logic              v0, v1, v2, v3;
  mode_e             m0, m1, m2;
  logic [TAG_W-1:0]  t0, t1, t2, t3;

  assign in_mode_e = mode_e'(in_mode);
  assign adv       = ~v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign out_tag   = t3;

  // control sideband: valid, mode and tag shift together, all hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      m0 <= MODE_CT; m1 <= MODE_CT; m2 <= MODE_CT;
      t0 <= '0; t1 <= '0; t2 <= '0; t3 <= '0;
    end else if (adv) begin
      v0 <= in_valid; v1 <= v0; v2 <= v1; v3 <= v2;
      m0 <= in_mode_e; m1 <= m0; m2 <= m1;
      t0 <= in_tag; t1 <= t0; t2 <= t1; t3 <= t2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] a_i, b_i, w_i;
    logic [W-1:0] sum_i, dif_i, gs_s, gs_d;
    logic [W-1:0] pa_d, pd_d, x_d, y_d;
    logic [W-1:0] pa0, pd0, x0, y0, w0;
    logic [W-1:0] pa1, pd1, pa2, pd2;
    logic [W-1:0] rx, ry;
    logic [W-1:0] o0_d, o1_d, o0_q, o1_q;

    assign a_i = in_a[i*W +: W];
    assign b_i = in_b[i*W +: W];
    assign w_i = in_tw[i*W +: W];

    // S0 operand steering: pass-through value, difference, and the two multiplicands
    always_comb begin
      sum_i = add_mod(a_i, b_i);
      dif_i = sub_mod(a_i, b_i);
      gs_s  = in_half ? half_mod(sum_i) : sum_i;
      gs_d  = in_half ? half_mod(dif_i) : dif_i;
      pa_d  = a_i;
      pd_d  = dif_i;
      x_d   = b_i;
      y_d   = '0;
      case (in_mode_e)
        MODE_CT:     ;
        MODE_GS:     begin pa_d = gs_s; x_d = gs_d; end
        MODE_ADDSUB: begin pa_d = sum_i; x_d = '0; end
        MODE_MUL:    begin x_d = a_i; y_d = b_i; end
        default:     ;
      endcase
    end

    // S0..S2 data registers; the pass-through values track the multiplier latency
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pa0 <= '0; pd0 <= '0; x0 <= '0; y0 <= '0; w0 <= '0;
        pa1 <= '0; pd1 <= '0; pa2 <= '0; pd2 <= '0;
      end else if (adv) begin
        pa0 <= pa_d; pd0 <= pd_d; x0 <= x_d; y0 <= y_d; w0 <= w_i;
        pa1 <= pa0; pd1 <= pd0;
        pa2 <= pa1; pd2 <= pd1;
      end
    end

    mod_mul_barrett #(.W(W), .Q(Q)) u_mul_x (
      .clk(clk), .rst_n(rst_n), .en(adv), .x(x0), .y(w0), .r(rx)
    );

    mod_mul_barrett #(.W(W), .Q(Q)) u_mul_y (
      .clk(clk), .rst_n(rst_n), .en(adv), .x(y0), .y(w0), .r(ry)
    );

    // S3 result selection, including the CT post add/sub
    always_comb begin
      o0_d = pa2;
      o1_d = pd2;
      case (m2)
        MODE_CT:     begin o0_d = add_mod(pa2, rx); o1_d = sub_mod(pa2, rx); end
        MODE_GS:     begin o0_d = pa2; o1_d = rx; end
        MODE_ADDSUB: begin o0_d = pa2; o1_d = pd2; end
        MODE_MUL:    begin o0_d = rx; o1_d = ry; end
        default:     ;
      endcase
    end

    // S3 output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o0_q <= '0;
        o1_q <= '0;
      end else if (adv) begin
        o0_q <= o0_d;
        o1_q <= o1_d;
      end
    end

    assign out_0[i*W +: W] = o0_q;
    assign out_1[i*W +: W] = o1_q;
  end

endmodule

// File: tb/tb_butterfly_array.sv
// Self-checking bench for butterfly_array: directed vectors, backpressure,
// mid-stream reset and a randomized stream against an arithmetic model.
module tb_butterfly_array;

  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int LANES = 2;
  localparam int TAG_W = 8;
  localparam int LW    = LANES * W;
  localparam int INV2  = (Q + 1) / 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic              in_half;
  logic [LW-1:0]     in_a, in_b, in_tw;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     out_0, out_1;
  logic [TAG_W-1:0]  out_tag;

  butterfly_array #(.W(W), .Q(Q), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_half(in_half),
    .in_a(in_a), .in_b(in_b), .in_tw(in_tw), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_0(out_0), .out_1(out_1), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [LW-1:0]    o0;
    logic [LW-1:0]    o1;
  } exp_t;

  exp_t         exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic         in_fire, out_fire;
  logic         dir_en = 1'b0;
  logic [LW-1:0] dir_o0, dir_o1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pk(input int l0, input int l1);
    return {W'(l1), W'(l0)};
  endfunction

  // reference: plain modular arithmetic per lane; halving is multiplication by 2^-1 mod Q
  function automatic exp_t model(input logic [1:0] mode, input logic half,
                                 input logic [LW-1:0] av, input logic [LW-1:0] bv,
                                 input logic [LW-1:0] wv, input logic [TAG_W-1:0] tag);
    exp_t e;
    int a, b, w, s, d, t, r0, r1;
    e.tag = tag; e.o0 = '0; e.o1 = '0;
    for (int i = 0; i < LANES; i++) begin
      a = int'(av[i*W +: W]); b = int'(bv[i*W +: W]); w = int'(wv[i*W +: W]);
      case (mode)
        2'b00: begin t = (b * w) % Q; r0 = (a + t) % Q; r1 = (a - t + Q) % Q; end
        2'b01: begin
          s = (a + b) % Q; d = (a - b + Q) % Q;
          if (half) begin s = (s * INV2) % Q; d = (d * INV2) % Q; end
          r0 = s; r1 = (d * w) % Q;
        end
        2'b10: begin r0 = (a + b) % Q; r1 = (a - b + Q) % Q; end
        default: begin r0 = (a * w) % Q; r1 = (b * w) % Q; end
      endcase
      e.o0[i*W +: W] = W'(r0);
      e.o1[i*W +: W] = W'(r1);
    end
    return e;
  endfunction

  // one clock: sample handshakes away from the edge, score outputs, record accepted beats
  task automatic tick();
    exp_t e;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (out_fire) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_tag", out_tag, e.tag);
        check("out_0", out_0, e.o0);
        check("out_1", out_1, e.o1);
      end
    end
    if (in_fire) begin
      if (dir_en) begin
        e.tag = in_tag; e.o0 = dir_o0; e.o1 = dir_o1;
      end else begin
        e = model(in_mode, in_half, in_a, in_b, in_tw, in_tag);
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [1:0] mode, input logic half, input logic [LW-1:0] a,
                          input logic [LW-1:0] b, input logic [LW-1:0] w, input logic [TAG_W-1:0] tag);
    in_mode = mode; in_half = half; in_a = a; in_b = b; in_tw = w; in_tag = tag;
  endtask

  task automatic rand_beat(input logic [TAG_W-1:0] tag);
    in_mode = 2'($urandom_range(3));
    in_half = 1'($urandom_range(1));
    for (int i = 0; i < LANES; i++) begin
      in_a[i*W +: W]  = W'($urandom_range(Q - 1));
      in_b[i*W +: W]  = W'($urandom_range(Q - 1));
      in_tw[i*W +: W] = W'($urandom_range(Q - 1));
    end
    in_tag = tag;
  endtask

  task automatic send_dir(input logic [1:0] mode, input logic half, input logic [LW-1:0] a,
                          input logic [LW-1:0] b, input logic [LW-1:0] w, input logic [TAG_W-1:0] tag,
                          input logic [LW-1:0] e0, input logic [LW-1:0] e1);
    set_beat(mode, half, a, b, w, tag);
    dir_o0 = e0; dir_o1 = e1; dir_en = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("dir_accept", in_fire, 1);
    dir_en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int sent, got, prepared, stall_left;
    logic stalled;
    logic [LW-1:0] cap0, cap1;
    logic [TAG_W-1:0] capt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_beat(2'b00, 1'b0, '0, '0, '0, '0);
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_0", out_0, 0);
    check("rst_out_1", out_1, 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // CT on lane 0 with latency check
    send_dir(2'b00, 1'b0, pk(1000, 0), pk(2000, 0), pk(17, 0), 8'h11, pk(1710, 0), pk(290, 0));
    for (int k = 0; k < 3; k++) begin
      check("lat_not_yet", out_valid, 0);
      tick();
    end
    check("lat_valid", out_valid, 1);
    drain();

    // CT boundaries, GS with and without halving
    send_dir(2'b00, 1'b0, pk(3328, 0), pk(3328, 1), pk(3328, 1), 8'h21, pk(0, 1), pk(3327, 3328));
    send_dir(2'b01, 1'b1, pk(3, 0), pk(0, 0), pk(1, 0), 8'h22, pk(1666, 0), pk(1666, 0));
    send_dir(2'b01, 1'b0, pk(5, 0), pk(7, 0), pk(2, 0), 8'h23, pk(12, 0), pk(3325, 0));
    // mixed stream: ADDSUB on lane 0, then MUL on lane 1
    send_dir(2'b10, 1'b0, pk(3000, 0), pk(400, 0), pk(1234, 0), 8'h5A, pk(71, 0), pk(2600, 0));
    send_dir(2'b11, 1'b0, pk(0, 2), pk(0, 3), pk(0, 1700), 8'hA5, pk(0, 71), pk(0, 1771));
    drain();

    // backpressure: 8 back-to-back beats, 3-cycle stall at the first output
    sent = 0; got = 0; prepared = -1; stall_left = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      if (sent != prepared) begin rand_beat(TAG_W'(sent)); prepared = sent; end
      in_valid = (sent < 8);
      if (out_valid && !stalled) begin
        stalled = 1'b1; stall_left = 3;
        cap0 = out_0; cap1 = out_1; capt = out_tag;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        if (stall_left < 3) begin
          check("stall_out_0", out_0, cap0);
          check("stall_out_1", out_1, cap1);
          check("stall_out_tag", out_tag, capt);
        end
        stall_left--;
      end
      tick();
      if (in_fire) sent++;
      if (out_fire) got++;
    end
    check("bp_delivered", got, 8);
    check("bp_stalled", stalled, 1);
    drain();

    // randomized stream with random valid and ready
    for (int k = 0; k < 300; k++) begin
      rand_beat(TAG_W'(k));
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      tick();
    end
    drain();

    // reset with beats in flight, one of them at the output
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_beat(TAG_W'(8'hC0 + k));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("rst_mid_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_0", out_0, 0);
    check("rst_mid_out_tag", out_tag, 0);
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("rst_no_stale", out_valid, 0);
      tick();
    end
    rand_beat(8'hEE);
    in_valid = 1'b1;
    tick();
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
